// File: rtl/safe_lock_ctrl_if.sv
// Keypad, timer and status signals shared between the safe lock controller
// and whatever drives the keypad and hosts the countdown timer.
interface safe_lock_ctrl_if;
  // keypad and timer inputs to the controller
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_enter;
  logic       key_clear;
  logic       key_set;
  logic       key_lock;
  logic       time_out;
  // controller outputs
  logic       run_timer;
  logic       reset_timer;
  logic       timer_mode_5min;
  logic       door_open;
  logic       locked_out;
  logic [1:0] fail_cnt;
  logic       entry_err;
  logic [2:0] state;

  // keypad/timer side
  modport master (
    output key_valid, key_digit, key_enter, key_clear, key_set, key_lock, time_out,
    input  run_timer, reset_timer, timer_mode_5min, door_open, locked_out,
           fail_cnt, entry_err, state
  );

  // controller side
  modport slave (
    input  key_valid, key_digit, key_enter, key_clear, key_set, key_lock, time_out,
    output run_timer, reset_timer, timer_mode_5min, door_open, locked_out,
           fail_cnt, entry_err, state
  );
endinterface

// File: rtl/safe_lock_ctrl.sv
// Safe lock controller: collects BCD keypad digits, checks them against the
// stored password, counts consecutive failures, drives the countdown timer
// (1-minute entry window, 5-minute lockout) and allows a password change
// while the door is open. Every output comes straight from a register.
// PW_DIGITS is expected to be at least 2.
module safe_lock_ctrl #(
  parameter int                       PW_DIGITS  = 4,
  parameter int                       MAX_FAIL   = 3,
  parameter logic [4*PW_DIGITS-1:0]   DEFAULT_PW = 16'h1234
) (
  input  logic             clk,
  input  logic             rst,
  safe_lock_ctrl_if.slave  bus
);

  localparam int BW = 4 * PW_DIGITS;
  localparam int CW = $clog2(PW_DIGITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(PW_DIGITS);
  localparam logic [CW-1:0] CNT_OVF  = CW'(PW_DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_SET     = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] pw_q, pw_d;
  logic [1:0]    fail_q, fail_d;
  logic          armed_q, armed_d;
  logic          run_q, run_d;
  logic          rt_q, rt_d;
  logic          mode_q, mode_d;
  logic          door_q, door_d;
  logic          lo_q, lo_d;
  logic          err_q, err_d;

  logic          digit_ok;
  logic [BW-1:0] buf_shift;
  logic [CW-1:0] cnt_inc;
  logic          fail_hit;
  logic          pw_match;
  logic          timeout_ok;

  // Digits 10-15 are not BCD and are dropped; the count sticks one past full
  // so an over-long entry can never match.
  assign digit_ok   = bus.key_valid && (bus.key_digit <= 4'd9);
  assign buf_shift  = {buf_q[BW-5:0], bus.key_digit};
  assign cnt_inc    = (cnt_q == CNT_OVF) ? cnt_q : cnt_q + 1'b1;
  assign fail_hit   = ({1'b0, fail_q} + 3'd1) == 3'(MAX_FAIL);
  assign pw_match   = (cnt_q == CNT_FULL) && (buf_q == pw_q);
  // A time_out seen right after a reload may still belong to the previous
  // countdown, so it only counts once armed.
  assign timeout_ok = bus.time_out && armed_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, datapath updates and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    fail_d  = fail_q;
    rt_d    = 1'b0;
    mode_d  = mode_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (digit_ok) begin
          buf_d   = BW'(bus.key_digit);
          cnt_d   = CW'(1);
          state_d = S_ENTRY;
          rt_d    = 1'b1;
          mode_d  = 1'b0;
        end
      end

      S_ENTRY: begin
        if (timeout_ok) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          if (digit_ok) begin
            buf_d = buf_shift;
            cnt_d = cnt_inc;
          end
          if (bus.key_clear) begin
            buf_d = '0;
            cnt_d = '0;
          end
          if (bus.key_enter) state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (pw_match) begin
          state_d = S_OPEN;
          fail_d  = 2'd0;
        end else begin
          err_d = 1'b1;
          if (fail_hit) begin
            state_d = S_LOCKOUT;
            fail_d  = 2'd0;
            rt_d    = 1'b1;
            mode_d  = 1'b1;
          end else begin
            state_d = S_ENTRY;
            fail_d  = fail_q + 2'd1;
          end
        end
      end

      S_LOCKOUT: begin
        if (timeout_ok) begin
          state_d = S_IDLE;
          mode_d  = 1'b0;
        end
      end

      S_OPEN: begin
        if (bus.key_lock) begin
          state_d = S_IDLE;
        end else if (bus.key_set) begin
          state_d = S_SET;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end

      S_SET: begin
        if (bus.key_lock) begin
          state_d = S_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (bus.key_enter) begin
          if (cnt_q == CNT_FULL) pw_d  = buf_q;
          else                   err_d = 1'b1;
          state_d = S_OPEN;
          buf_d   = '0;
          cnt_d   = '0;
        end else begin
          if (digit_ok) begin
            buf_d = buf_shift;
            cnt_d = cnt_inc;
          end
          if (bus.key_clear) begin
            buf_d = '0;
            cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        buf_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Level outputs follow the state being entered so they line up with it.
    run_d   = (state_d == S_ENTRY) || (state_d == S_CHECK) || (state_d == S_LOCKOUT);
    door_d  = (state_d == S_OPEN) || (state_d == S_SET);
    lo_d    = (state_d == S_LOCKOUT);
    // Disarmed during the reload pulse cycle and the cycle after it.
    armed_d = !(rt_d || rt_q);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      pw_q    <= DEFAULT_PW;
      fail_q  <= 2'd0;
      armed_q <= 1'b0;
      run_q   <= 1'b0;
      rt_q    <= 1'b0;
      mode_q  <= 1'b0;
      door_q  <= 1'b0;
      lo_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      fail_q  <= fail_d;
      armed_q <= armed_d;
      run_q   <= run_d;
      rt_q    <= rt_d;
      mode_q  <= mode_d;
      door_q  <= door_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign bus.run_timer       = run_q;
  assign bus.reset_timer     = rt_q;
  assign bus.timer_mode_5min = mode_q;
  assign bus.door_open       = door_q;
  assign bus.locked_out      = lo_q;
  assign bus.fail_cnt        = fail_q;
  assign bus.entry_err       = err_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Bench for safe_lock_ctrl: each scenario builds a list of keypad/timer steps
// with the expected output snapshot after each clock, pushes the expectation
// into a scoreboard queue as the step is driven and pops it when the
// registered outputs are sampled.
module tb_safe_lock_ctrl;

  localparam logic [2:0] ID = 3'd0, EN = 3'd1, CH = 3'd2, OP = 3'd3, ST = 3'd4, LO = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  safe_lock_ctrl_if bus();

  safe_lock_ctrl #(.PW_DIGITS(4), .MAX_FAIL(3), .DEFAULT_PW(16'h1234)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        v;
    logic [3:0]  d;
    logic        e, c, s, l, to;
    logic [10:0] x;
  } stim_t;

  logic [10:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  // snapshot layout: {state, run_timer, reset_timer, mode_5min, door_open, locked_out, fail_cnt, entry_err}
  function automatic logic [10:0] ex(input logic [2:0] st, input logic run, input logic rt,
                                     input logic mode, input logic door, input logic lo,
                                     input logic [1:0] fc, input logic err);
    return {st, run, rt, mode, door, lo, fc, err};
  endfunction

  function automatic logic [10:0] obs();
    return {bus.state, bus.run_timer, bus.reset_timer, bus.timer_mode_5min,
            bus.door_open, bus.locked_out, bus.fail_cnt, bus.entry_err};
  endfunction

  function automatic stim_t mk(input logic v, input logic [3:0] d, input logic e, input logic c,
                               input logic s, input logic l, input logic to, input logic [10:0] x);
    stim_t r;
    r.v = v; r.d = d; r.e = e; r.c = c; r.s = s; r.l = l; r.to = to; r.x = x;
    return r;
  endfunction

  function automatic stim_t dig(input logic [3:0] d, input logic [10:0] x);
    return mk(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, x);
  endfunction

  function automatic stim_t ent(input logic [10:0] x);
    return mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, x);
  endfunction

  function automatic stim_t nop(input logic [10:0] x);
    return mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, x);
  endfunction

  task automatic drive(input stim_t s);
    bus.key_valid = s.v;
    bus.key_digit = s.d;
    bus.key_enter = s.e;
    bus.key_clear = s.c;
    bus.key_set   = s.s;
    bus.key_lock  = s.l;
    bus.time_out  = s.to;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_enter = 1'b0;
    bus.key_clear = 1'b0;
    bus.key_set   = 1'b0;
    bus.key_lock  = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    got = obs();
    tests_run++;
    if (got !== ex(ID, 0, 0, 0, 0, 0, 2'd0, 0)) begin
      tests_failed++;
      $display("FAIL reset_state got=%b want=%b", got, ex(ID, 0, 0, 0, 0, 0, 2'd0, 0));
    end else $display("[TB] reset_state ok %b", got);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_correct_entry();
    stim_t q[$];
    logic [10:0] got, want;
    q.push_back(dig(4'd1, ex(EN, 1, 1, 0, 0, 0, 2'd0, 0)));
    q.push_back(dig(4'd2, ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(dig(4'd3, ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(dig(4'd4, ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(ent(ex(CH, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(nop(ex(OP, 0, 0, 0, 1, 0, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 0, 0, 1, 0, ex(ID, 0, 0, 0, 0, 0, 2'd0, 0)));
    foreach (q[i]) begin
      exp_q.push_back(q[i].x);
      drive(q[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL correct_entry[%0d] got=%b want=%b", i, got, want);
      end else $display("[TB] correct_entry[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_lockout();
    stim_t q[$];
    logic [10:0] got, want;
    for (int a = 0; a < 3; a++) begin
      for (int k = 0; k < 4; k++)
        q.push_back(dig(4'd9, ex(EN, 1, (a == 0 && k == 0), 0, 0, 0, 2'(a), 0)));
      q.push_back(ent(ex(CH, 1, 0, 0, 0, 0, 2'(a), 0)));
      if (a < 2) q.push_back(nop(ex(EN, 1, 0, 0, 0, 0, 2'(a + 1), 1)));
      else       q.push_back(nop(ex(LO, 1, 1, 1, 0, 1, 2'd0, 1)));
    end
    // keys have no effect while locked out
    q.push_back(dig(4'd1, ex(LO, 1, 0, 1, 0, 1, 2'd0, 0)));
    q.push_back(ent(ex(LO, 1, 0, 1, 0, 1, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 1, 1, 1, 0, ex(LO, 1, 0, 1, 0, 1, 2'd0, 0)));
    // armed timeout ends the lockout; time_out stays high afterwards
    q.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, ex(ID, 0, 0, 0, 0, 0, 2'd0, 0)));
    foreach (q[i]) begin
      exp_q.push_back(q[i].x);
      drive(q[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL lockout[%0d] got=%b want=%b", i, got, want);
      end else $display("[TB] lockout[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_stale_timeout();
    stim_t q[$];
    logic [10:0] got, want;
    q.push_back(mk(1, 4'd5, 0, 0, 0, 0, 1, ex(EN, 1, 1, 0, 0, 0, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    foreach (q[i]) begin
      exp_q.push_back(q[i].x);
      drive(q[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL stale_timeout[%0d] got=%b want=%b", i, got, want);
      end else $display("[TB] stale_timeout[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_entry_timeout();
    stim_t q[$];
    logic [10:0] got, want;
    // buffer holds 5 from the previous scenario; finish a wrong attempt
    for (int k = 0; k < 3; k++) q.push_back(dig(4'd6, ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(ent(ex(CH, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(nop(ex(EN, 1, 0, 0, 0, 0, 2'd1, 1)));
    q.push_back(dig(4'd5, ex(EN, 1, 0, 0, 0, 0, 2'd1, 0)));
    // timeout beats a digit and enter arriving in the same cycle
    q.push_back(mk(1, 4'd7, 1, 0, 0, 0, 1, ex(ID, 0, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(nop(ex(ID, 0, 0, 0, 0, 0, 2'd1, 0)));
    // buffer was cleared, so a clean 1234 opens
    q.push_back(dig(4'd1, ex(EN, 1, 1, 0, 0, 0, 2'd1, 0)));
    q.push_back(dig(4'd2, ex(EN, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(dig(4'd3, ex(EN, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(dig(4'd4, ex(EN, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(ent(ex(CH, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(nop(ex(OP, 0, 0, 0, 1, 0, 2'd0, 0)));
    // time_out is ignored while open
    q.push_back(mk(0, 4'd0, 0, 0, 0, 0, 1, ex(OP, 0, 0, 0, 1, 0, 2'd0, 0)));
    q.push_back(nop(ex(OP, 0, 0, 0, 1, 0, 2'd0, 0)));
    foreach (q[i]) begin
      exp_q.push_back(q[i].x);
      drive(q[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL entry_timeout[%0d] got=%b want=%b", i, got, want);
      end else $display("[TB] entry_timeout[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_password_change();
    stim_t q[$];
    logic [10:0] got, want;
    logic [3:0] np[4];
    np = '{4'd4, 4'd3, 4'd2, 4'd1};
    q.push_back(mk(0, 4'd0, 0, 0, 1, 0, 0, ex(ST, 0, 0, 0, 1, 0, 2'd0, 0)));
    for (int k = 0; k < 4; k++) q.push_back(dig(np[k], ex(ST, 0, 0, 0, 1, 0, 2'd0, 0)));
    q.push_back(ent(ex(OP, 0, 0, 0, 1, 0, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 0, 0, 1, 0, ex(ID, 0, 0, 0, 0, 0, 2'd0, 0)));
    // old password now fails
    for (int k = 0; k < 4; k++) q.push_back(dig(4'(k + 1), ex(EN, 1, (k == 0), 0, 0, 0, 2'd0, 0)));
    q.push_back(ent(ex(CH, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(nop(ex(EN, 1, 0, 0, 0, 0, 2'd1, 1)));
    // new password opens
    for (int k = 0; k < 4; k++) q.push_back(dig(np[k], ex(EN, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(ent(ex(CH, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(nop(ex(OP, 0, 0, 0, 1, 0, 2'd0, 0)));
    // three-digit set is rejected
    q.push_back(mk(0, 4'd0, 0, 0, 1, 0, 0, ex(ST, 0, 0, 0, 1, 0, 2'd0, 0)));
    for (int k = 0; k < 3; k++) q.push_back(dig(4'd9, ex(ST, 0, 0, 0, 1, 0, 2'd0, 0)));
    q.push_back(ent(ex(OP, 0, 0, 0, 1, 0, 2'd0, 1)));
    q.push_back(mk(0, 4'd0, 0, 0, 0, 1, 0, ex(ID, 0, 0, 0, 0, 0, 2'd0, 0)));
    // 4321 still opens
    for (int k = 0; k < 4; k++) q.push_back(dig(np[k], ex(EN, 1, (k == 0), 0, 0, 0, 2'd0, 0)));
    q.push_back(ent(ex(CH, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(nop(ex(OP, 0, 0, 0, 1, 0, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 0, 0, 1, 0, ex(ID, 0, 0, 0, 0, 0, 2'd0, 0)));
    foreach (q[i]) begin
      exp_q.push_back(q[i].x);
      drive(q[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL password_change[%0d] got=%b want=%b", i, got, want);
      end else $display("[TB] password_change[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_mid_entry_reset();
    stim_t q[$];
    logic [10:0] got, want;
    q.push_back(dig(4'd1, ex(EN, 1, 1, 0, 0, 0, 2'd0, 0)));
    q.push_back(dig(4'd2, ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    foreach (q[i]) begin
      exp_q.push_back(q[i].x);
      drive(q[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL mid_reset_pre[%0d] got=%b want=%b", i, got, want);
      end else $display("[TB] mid_reset_pre[%0d] ok %b", i, got);
    end
    // reset takes effect without waiting for a clock edge
    rst = 1'b1;
    #2;
    got = obs();
    tests_run++;
    if (got !== ex(ID, 0, 0, 0, 0, 0, 2'd0, 0)) begin
      tests_failed++;
      $display("FAIL mid_reset_async got=%b want=%b", got, ex(ID, 0, 0, 0, 0, 0, 2'd0, 0));
    end else $display("[TB] mid_reset_async ok %b", got);
    @(posedge clk); #1;
    rst = 1'b0;
    // password is back to 1234; lock together with set relocks
    q.delete();
    for (int k = 0; k < 4; k++) q.push_back(dig(4'(k + 1), ex(EN, 1, (k == 0), 0, 0, 0, 2'd0, 0)));
    q.push_back(ent(ex(CH, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(nop(ex(OP, 0, 0, 0, 1, 0, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 0, 1, 1, 0, ex(ID, 0, 0, 0, 0, 0, 2'd0, 0)));
    foreach (q[i]) begin
      exp_q.push_back(q[i].x);
      drive(q[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL mid_reset_post[%0d] got=%b want=%b", i, got, want);
      end else $display("[TB] mid_reset_post[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_edge_cases();
    stim_t q[$];
    logic [10:0] got, want;
    // five digits ending in 1234 overflow and mismatch
    q.push_back(dig(4'd9, ex(EN, 1, 1, 0, 0, 0, 2'd0, 0)));
    for (int k = 0; k < 4; k++) q.push_back(dig(4'(k + 1), ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(ent(ex(CH, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(nop(ex(EN, 1, 0, 0, 0, 0, 2'd1, 1)));
    // digit 12 is ignored
    q.push_back(dig(4'd1,  ex(EN, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(dig(4'd2,  ex(EN, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(dig(4'd12, ex(EN, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(dig(4'd3,  ex(EN, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(dig(4'd4,  ex(EN, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(ent(ex(CH, 1, 0, 0, 0, 0, 2'd1, 0)));
    q.push_back(nop(ex(OP, 0, 0, 0, 1, 0, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 0, 0, 1, 0, ex(ID, 0, 0, 0, 0, 0, 2'd0, 0)));
    // clear discards earlier digits; last digit with enter is captured first
    q.push_back(dig(4'd7, ex(EN, 1, 1, 0, 0, 0, 2'd0, 0)));
    q.push_back(dig(4'd7, ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 1, 0, 0, 0, ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    for (int k = 0; k < 3; k++) q.push_back(dig(4'(k + 1), ex(EN, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(mk(1, 4'd4, 1, 0, 0, 0, 0, ex(CH, 1, 0, 0, 0, 0, 2'd0, 0)));
    q.push_back(nop(ex(OP, 0, 0, 0, 1, 0, 2'd0, 0)));
    q.push_back(mk(0, 4'd0, 0, 0, 1, 1, 0, ex(ID, 0, 0, 0, 0, 0, 2'd0, 0)));
    foreach (q[i]) begin
      exp_q.push_back(q[i].x);
      drive(q[i]);
      got = obs();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL edge_cases[%0d] got=%b want=%b", i, got, want);
      end else $display("[TB] edge_cases[%0d] ok %b", i, got);
    end
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.key_enter = 1'b0;
    bus.key_clear = 1'b0;
    bus.key_set   = 1'b0;
    bus.key_lock  = 1'b0;
    bus.time_out  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_correct_entry();
    test_lockout();
    test_stale_timeout();
    test_entry_timeout();
    bus.key_lock = 1'b1;
    @(posedge clk); #1;
    bus.key_lock = 1'b0;
    bus.key_set  = 1'b1;
    bus.key_lock = 1'b1;
    @(posedge clk); #1;
    bus.key_set  = 1'b0;
    bus.key_lock = 1'b0;
    // back in IDLE; reopen to start the password change
    for (int k = 0; k < 4; k++) begin
      bus.key_valid = 1'b1;
      bus.key_digit = 4'(k + 1);
      @(posedge clk); #1;
    end
    bus.key_valid = 1'b0;
    bus.key_enter = 1'b1;
    @(posedge clk); #1;
    bus.key_enter = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus.door_open !== 1'b1) begin
      tests_failed++;
      $display("FAIL reopen door_open=%b want=1", bus.door_open);
    end else $display("[TB] reopen ok door_open=%b", bus.door_open);
    test_password_change();
    test_mid_entry_reset();
    test_edge_cases();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
